// File: rtl/button_debounce.sv
// Debounced push-button with PRESS/RELEASE pulses and an optional LONG_PRESS pulse.
// Define BUTTON_DEBOUNCE_LONGPRESS_EN to build the hold counter; otherwise LONG_PRESS is tied to 0.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned HOLD_CYCLES     = 12000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic PRESSED,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG_PRESS
);

    localparam logic [1:0] ST_UP      = 2'd0;
    localparam logic [1:0] ST_DN_PEND = 2'd1;
    localparam logic [1:0] ST_DOWN    = 2'd2;
    localparam logic [1:0] ST_UP_PEND = 2'd3;

    localparam logic [23:0] DEB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32'h00FF_FFFF ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 32'h03FF_FFFF) begin : g_bad_param
        $error("button_debounce: DEBOUNCE_CYCLES or HOLD_CYCLES out of range");
    end

    logic        sync1_q, sync_q;
    logic [1:0]  state_q, state_d;
    logic [23:0] deb_cnt_q, deb_cnt_d;
    logic        pressed_q, pressed_d;
    logic        press_q, press_d;
    logic        release_q, release_d;

    // The counter only advances while a PEND state keeps seeing its target level,
    // so it is zero on every PEND entry and never exceeds DEB_LAST.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = '0;
        case (state_q)
            ST_UP: begin
                if (sync_q) state_d = ST_DN_PEND;
            end
            ST_DN_PEND: begin
                if (!sync_q)                    state_d = ST_UP;
                else if (deb_cnt_q == DEB_LAST) state_d = ST_DOWN;
                else                            deb_cnt_d = deb_cnt_q + 24'd1;
            end
            ST_DOWN: begin
                if (!sync_q) state_d = ST_UP_PEND;
            end
            ST_UP_PEND: begin
                if (sync_q)                     state_d = ST_DOWN;
                else if (deb_cnt_q == DEB_LAST) state_d = ST_UP;
                else                            deb_cnt_d = deb_cnt_q + 24'd1;
            end
            default: state_d = ST_UP;
        endcase

        pressed_d = (state_d == ST_DOWN) || (state_d == ST_UP_PEND);
        press_d   = pressed_d && !pressed_q;
        release_d = !pressed_d && pressed_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q   <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= ST_UP;
            deb_cnt_q <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= BTN;
            sync_q    <= sync1_q;
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign PRESSED = pressed_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam logic [25:0] HOLD_MAX = 26'(HOLD_CYCLES);

    logic [25:0] hold_q, hold_d;
    logic        long_press_q, long_press_d;

    // Saturating at HOLD_MAX makes the pulse fire once per press, and a rejected
    // UP_PEND glitch keeps counting because UP_PEND still counts as held.
    always_comb begin
        hold_d       = '0;
        long_press_d = 1'b0;
        if (state_q == ST_DOWN || state_q == ST_UP_PEND) begin
            if (hold_q != HOLD_MAX) begin
                hold_d       = hold_q + 26'd1;
                long_press_d = (hold_d == HOLD_MAX);
            end else begin
                hold_d = hold_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hold_q       <= '0;
            long_press_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            long_press_q <= long_press_d;
        end
    end

    assign LONG_PRESS = long_press_q;
`else
    assign LONG_PRESS = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10).
// Expected output vectors {PRESSED,PRESS,RELEASE,LONG_PRESS} are queued per driven cycle.
module tb_button_debounce;

    logic CLK;
    logic RST_N;
    logic BTN;
    logic PRESSED, PRESS, RELEASE, LONG_PRESS;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BTN       (BTN),
        .PRESSED   (PRESSED),
        .PRESS     (PRESS),
        .RELEASE   (RELEASE),
        .LONG_PRESS(LONG_PRESS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs ahead of the next rising edge and queues what that edge must produce.
    task automatic applyStimulus(input logic btn, input logic rst_n, input logic [3:0] exp,
                                 input string tag);
        exp_t e;
        @(negedge CLK);
        BTN   = btn;
        RST_N = rst_n;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [3:0] vec(input bit pressed, input bit press, input bit rel,
                                       input bit lp);
        return {pressed, press, rel, lp};
    endfunction

    always @(posedge CLK) begin
        exp_t e;
        #4;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, {28'd0, PRESSED, PRESS, RELEASE, LONG_PRESS}, {28'd0, e.exp});
        end
    end

    task automatic releaseAndIdle(input string name);
        for (int j = 0; j < 12; j++)
            applyStimulus(1'b0, 1'b1, vec(j < 6, 1'b0, j == 6, 1'b0),
                          $sformatf("%s_rel[%0d]", name, j));
        for (int j = 0; j < 4; j++)
            applyStimulus(1'b0, 1'b1, 4'b0000, $sformatf("%s_idle[%0d]", name, j));
    endtask

    initial begin
        RST_N = 1'b0;
        BTN   = 1'b0;

        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 4'b0000, $sformatf("reset[%0d]", k));
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 4'b0000, $sformatf("idle[%0d]", k));

        // Clean press held 30 cycles, then a clean release.
        for (int k = 0; k < 30; k++)
            applyStimulus(1'b1, 1'b1, vec(k >= 6, k == 6, 1'b0, LP && (k == 16)),
                          $sformatf("press[%0d]", k));
        releaseAndIdle("press");

        // Bounce: 1x3, 0x2, 1x3, then 0 -- must be rejected.
        for (int k = 0; k < 18; k++) begin
            logic b;
            b = (k < 3) || (k >= 5 && k < 8);
            applyStimulus(b, 1'b1, 4'b0000, $sformatf("bounce[%0d]", k));
        end

        // Press with a 2-cycle release glitch in the middle; long press still at edge 16.
        for (int k = 0; k < 24; k++) begin
            logic b;
            b = !(k == 12 || k == 13);
            applyStimulus(b, 1'b1, vec(k >= 6, k == 6, 1'b0, LP && (k == 16)),
                          $sformatf("glitch[%0d]", k));
        end
        releaseAndIdle("glitch");

        // Reset asserted at edges 4 and 5 mid-debounce; press restarts from edge 6.
        for (int k = 0; k < 26; k++) begin
            logic r;
            r = !(k == 4 || k == 5);
            applyStimulus(1'b1, r, vec(k >= 12, k == 12, 1'b0, LP && (k == 22)),
                          $sformatf("rstmid[%0d]", k));
        end
        releaseAndIdle("rstmid");

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge CLK);
        #5;
        checkOutput("drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 120000, consecutive stable synchronized samples required to accept a level change; legal range 1..2^24-1.
REQ-002 SHALL provide parameter HOLD_CYCLES, default 12000000, cycles in DOWN before LONG_PRESS fires; legal range 1..2^26-1.
REQ-003 SHALL provide port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port RST_N  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port BTN  input  1  raw asynchronous button, 1 = pressed.
REQ-006 SHALL provide port PRESSED  output  1  debounced level, 1 = pressed.
REQ-007 SHALL provide port PRESS  output  1  one-cycle pulse on accepted press.
REQ-008 SHALL provide port RELEASE  output  1  one-cycle pulse on accepted release.
REQ-009 SHALL provide port LONG_PRESS  output  1  one-cycle pulse on long hold.

Function
REQ-010 SHALL pass BTN through a two-flop synchronizer before any other logic; only the second flop output (sync) is used downstream.
REQ-011 SHALL implement FSM states UP, DN_PEND, DOWN, UP_PEND.
REQ-012 Transitions: UP->DN_PEND when sync=1; DN_PEND->DOWN when sync=1 for DEBOUNCE_CYCLES consecutive cycles; DN_PEND->UP on any sync=0; DOWN->UP_PEND when sync=0; UP_PEND->UP when sync=0 for DEBOUNCE_CYCLES consecutive cycles; UP_PEND->DOWN on any sync=1.
REQ-013 Debounce counter SHALL clear on entry to each PEND state and on any return to a stable state; it SHALL never wrap.
REQ-014 PRESSED SHALL be 1 exactly in DOWN and UP_PEND; a glitch shorter than DEBOUNCE_CYCLES SHALL not change PRESSED or emit pulses.
REQ-015 For BTN held constant after an edge, PRESSED SHALL change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling the new BTN value.
REQ-016 PRESS SHALL be 1 for exactly the cycle PRESSED first reads 1; RELEASE SHALL be 1 for exactly the cycle PRESSED first reads 0; both registered, never simultaneous.
REQ-017 With DEBOUNCE_CYCLES=1 the FSM SHALL still pass through the PEND state for one cycle.
REQ-018 All outputs SHALL be registered; no combinational path from BTN to any output.

Reset
REQ-019 While RST_N=0 at a rising edge: synchronizer flops=0, state=UP, all counters=0, PRESSED=PRESS=RELEASE=LONG_PRESS=0.
REQ-020 Reset asserted mid-debounce or mid-hold SHALL abort the pending transition without emitting any pulse; after deassertion a held BTN=1 SHALL be treated as a new press.

Configuration
REQ-021 With macro BUTTON_DEBOUNCE_LONGPRESS_EN defined: hold counter increments each cycle in DOWN/UP_PEND, clears in UP/DN_PEND, saturates at HOLD_CYCLES; LONG_PRESS pulses one cycle when counter reaches HOLD_CYCLES, at most once per press, unaffected by rejected UP_PEND glitches.
REQ-022 Without BUTTON_DEBOUNCE_LONGPRESS_EN: no hold counter synthesized; LONG_PRESS tied to 0; port list unchanged.

Verification (bench: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10; edge 0 = first edge sampling BTN=1)
REQ-023 Clean press: BTN 0->1 held 30 cycles -> PRESS=1 only at edge 6; PRESSED=1 from edge 6.
REQ-024 Bounce: BTN=1 for 3 cycles, 0 for 2, 1 for 3, then 0 -> PRESS, RELEASE, PRESSED all stay 0.
REQ-025 Release: PRESSED=1, then BTN=0 held -> RELEASE=1 only 6 edges after first BTN=0 sample; PRESSED=0 same cycle; release glitch of 2 cycles -> no RELEASE.
REQ-026 Long press, macro defined: BTN=1 held 40 cycles -> LONG_PRESS=1 only at edge 16, single pulse; macro undefined -> LONG_PRESS=0 throughout.
REQ-027 Reset mid-operation: BTN=1, RST_N=0 at edge 4 for 2 cycles -> no PRESS during/after reset edges; PRESS at 6 edges after first post-reset edge; all outputs 0 during reset.
